// File: rtl/even_odd_pair_reader.sv
// Streams word pairs from the even/odd sample banks to the min/max finder and frames the run with Start.
// Latency: Go to first pair on ReadData is 3 cycles; one pair per cycle after that; Done arrives 1 cycle after ConsumerVaild.
// Backpressure: none; the finder must take a pair every cycle, and the run aborts with Error if ConsumerVaild never arrives.
module even_odd_pair_reader #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 5,
    parameter int CNT_W   = 6,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Go,
    input  logic [ADDR_W-1:0] BaseAddr,
    input  logic [CNT_W-1:0]  NumPairs,
    output logic [ADDR_W-1:0] AddrEven,
    output logic [ADDR_W-1:0] AddrOdd,
    output logic              RdEn,
    input  logic [DATA_W-1:0] RamDataEven,
    input  logic [DATA_W-1:0] RamDataOdd,
    output logic [DATA_W-1:0] ReadDataEven,
    output logic [DATA_W-1:0] ReadDataOdd,
    output logic              PairValid,
    output logic              Start,
    input  logic              ConsumerVaild,
    output logic              Busy,
    output logic              Done,
    output logic              Error
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        WAIT,
        FINISH
    } state_t;

    state_t state, state_nxt;

    logic              go_accept;
    logic              tmo_expire;

    logic [ADDR_W-1:0] addr_q;
    logic              rd_en_q;
    logic [CNT_W-1:0]  remaining;
    logic              rd_en_d;
    logic [DATA_W-1:0] data_even_q;
    logic [DATA_W-1:0] data_odd_q;
    logic              pair_vld_q;
    logic              start_q;
    logic              error_q;
    logic [TMO_W-1:0]  tmo_cnt;

    // State register; reset returns to IDLE even in the middle of a run.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus the state-decoded strobes. READ is held until the
    // registered RdEn has dropped, so DRAIN lines up with the last pair being
    // presented and WAIT starts on the first repeated (held) pair.
    always_comb begin
        state_nxt  = state;
        go_accept  = 1'b0;
        tmo_expire = 1'b0;
        Busy       = (state != IDLE);
        Done       = (state == FINISH);
        case (state)
            IDLE: begin
                if (Go) begin
                    go_accept = 1'b1;
                    state_nxt = (NumPairs == '0) ? FINISH : READ;
                end
            end
            READ: begin
                if (!rd_en_q) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (ConsumerVaild) begin
                    state_nxt = FINISH;
                end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                    tmo_expire = 1'b1;
                    state_nxt  = FINISH;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Address generator: one address per cycle from BaseAddr, wrapping
    // naturally at the bank size; RdEn drops after the last address.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q    <= '0;
            rd_en_q   <= 1'b0;
            remaining <= '0;
        end else if (go_accept && (NumPairs != '0)) begin
            addr_q    <= BaseAddr;
            rd_en_q   <= 1'b1;
            remaining <= NumPairs - CNT_W'(1);
        end else if (rd_en_q) begin
            if (remaining != '0) begin
                addr_q    <= addr_q + ADDR_W'(1);
                remaining <= remaining - CNT_W'(1);
            end else begin
                rd_en_q <= 1'b0;
            end
        end
    end

    // Capture stage: bank data is valid the cycle after RdEn, so register it
    // one cycle later and hold the last pair when no read is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_en_d     <= 1'b0;
            pair_vld_q  <= 1'b0;
            data_even_q <= '0;
            data_odd_q  <= '0;
        end else begin
            rd_en_d    <= rd_en_q;
            pair_vld_q <= rd_en_d;
            if (rd_en_d) begin
                data_even_q <= RamDataEven;
                data_odd_q  <= RamDataOdd;
            end
        end
    end

    // Start rises with the first fresh pair and stays up until the run ends;
    // the WAIT timer and the sticky Error flag live here as well.
    always_ff @(posedge clk) begin
        if (reset) begin
            start_q <= 1'b0;
            error_q <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            if ((state_nxt == FINISH) || (state_nxt == IDLE)) begin
                start_q <= 1'b0;
            end else if (rd_en_d) begin
                start_q <= 1'b1;
            end

            if (state == WAIT) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end else begin
                tmo_cnt <= '0;
            end

            if (go_accept) begin
                error_q <= 1'b0;
            end else if (tmo_expire) begin
                error_q <= 1'b1;
            end
        end
    end

    assign AddrEven     = addr_q;
    assign AddrOdd      = addr_q;
    assign RdEn         = rd_en_q;
    assign ReadDataEven = data_even_q;
    assign ReadDataOdd  = data_odd_q;
    assign PairValid    = pair_vld_q;
    assign Start        = start_q;
    assign Error        = error_q;

endmodule

// File: tb/tb_even_odd_pair_reader.sv
// Directed bench for even_odd_pair_reader with a two-bank synchronous RAM model.
// Cycle k means the interval after the k-th rising edge following Go's sampling edge.
// Outputs are sampled 1 time unit after each rising edge.
module tb_even_odd_pair_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        Go;
    logic [4:0]  BaseAddr;
    logic [5:0]  NumPairs;
    logic [4:0]  AddrEven;
    logic [4:0]  AddrOdd;
    logic        RdEn;
    logic [15:0] RamDataEven;
    logic [15:0] RamDataOdd;
    logic [15:0] ReadDataEven;
    logic [15:0] ReadDataOdd;
    logic        PairValid;
    logic        Start;
    logic        ConsumerVaild;
    logic        Busy;
    logic        Done;
    logic        Error;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem_even [32];
    logic [15:0] mem_odd  [32];
    logic [15:0] exp_e [4];
    logic [15:0] exp_o [4];
    logic [4:0]  exp_a [4];
    logic [15:0] fmin;
    logic [15:0] fmax;
    int          start_cnt;
    logic        done_seen;

    even_odd_pair_reader dut (
        .clk          (clk),
        .reset        (reset),
        .Go           (Go),
        .BaseAddr     (BaseAddr),
        .NumPairs     (NumPairs),
        .AddrEven     (AddrEven),
        .AddrOdd      (AddrOdd),
        .RdEn         (RdEn),
        .RamDataEven  (RamDataEven),
        .RamDataOdd   (RamDataOdd),
        .ReadDataEven (ReadDataEven),
        .ReadDataOdd  (ReadDataOdd),
        .PairValid    (PairValid),
        .Start        (Start),
        .ConsumerVaild(ConsumerVaild),
        .Busy         (Busy),
        .Done         (Done),
        .Error        (Error)
    );

    always #5 clk = ~clk;

    // Synchronous-read banks: data appears the cycle after the address edge.
    always @(posedge clk) begin
        if (RdEn) begin
            RamDataEven <= mem_even[AddrEven];
            RamDataOdd  <= mem_odd[AddrOdd];
        end
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rden"},  32'(RdEn), 32'(0));
        chk({tag, "_addre"}, 32'(AddrEven), 32'(0));
        chk({tag, "_addro"}, 32'(AddrOdd), 32'(0));
        chk({tag, "_rde"},   32'(ReadDataEven), 32'(0));
        chk({tag, "_rdo"},   32'(ReadDataOdd), 32'(0));
        chk({tag, "_pv"},    32'(PairValid), 32'(0));
        chk({tag, "_start"}, 32'(Start), 32'(0));
        chk({tag, "_busy"},  32'(Busy), 32'(0));
        chk({tag, "_done"},  32'(Done), 32'(0));
        chk({tag, "_err"},   32'(Error), 32'(0));
    endtask

    initial begin
        reset = 1'b1; Go = 1'b0; BaseAddr = '0; NumPairs = '0; ConsumerVaild = 1'b0;
        RamDataEven = '0; RamDataOdd = '0;
        for (int a = 0; a < 32; a++) begin
            mem_even[a] = 16'h0100 + 16'(a);
            mem_odd[a]  = 16'h0200 + 16'(a);
        end
        mem_even[0] = 16'd5; mem_even[1] = 16'd9; mem_even[2] = 16'd2; mem_even[3] = 16'd7;
        mem_odd[0]  = 16'd8; mem_odd[1]  = 16'd1; mem_odd[2]  = 16'd6; mem_odd[3]  = 16'd3;

        // ---- reset state ----
        cyc; cyc;
        chk_all_zero("reset");
        reset = 1'b0;
        cyc;

        // ---- basic run: base 0, 4 pairs ----
        exp_e = '{16'd5, 16'd9, 16'd2, 16'd7};
        exp_o = '{16'd8, 16'd1, 16'd6, 16'd3};
        BaseAddr = 5'd0; NumPairs = 6'd4; Go = 1'b1;
        cyc; Go = 1'b0;
        fmin = 16'hFFFF; fmax = 16'h0000;
        for (int c = 1; c <= 6; c++) begin
            chk("basic_rden",  32'(RdEn), 32'(c <= 4));
            chk("basic_pv",    32'(PairValid), 32'(c >= 3));
            chk("basic_start", 32'(Start), 32'(c >= 3));
            chk("basic_busy",  32'(Busy), 32'(1));
            if (c <= 4) begin
                chk("basic_addre", 32'(AddrEven), 32'(c - 1));
                chk("basic_addro", 32'(AddrOdd), 32'(c - 1));
            end
            if (c >= 3) begin
                chk("basic_rde", 32'(ReadDataEven), 32'(exp_e[c-3]));
                chk("basic_rdo", 32'(ReadDataOdd), 32'(exp_o[c-3]));
                if (PairValid && Start) begin
                    if (ReadDataEven < fmin) fmin = ReadDataEven;
                    if (ReadDataOdd  < fmin) fmin = ReadDataOdd;
                    if (ReadDataEven > fmax) fmax = ReadDataEven;
                    if (ReadDataOdd  > fmax) fmax = ReadDataOdd;
                end
            end
            cyc;
        end
        // cycle 7: WAIT holds the last pair
        chk("basic_wait_pv",    32'(PairValid), 32'(0));
        chk("basic_wait_start", 32'(Start), 32'(1));
        chk("basic_wait_rde",   32'(ReadDataEven), 32'(7));
        chk("basic_wait_rdo",   32'(ReadDataOdd), 32'(3));
        cyc; // cycle 8
        ConsumerVaild = 1'b1;
        chk("basic_c8_start", 32'(Start), 32'(1));
        chk("basic_c8_done",  32'(Done), 32'(0));
        cyc; ConsumerVaild = 1'b0; // cycle 9
        chk("basic_fin_start", 32'(Start), 32'(0));
        chk("basic_fin_done",  32'(Done), 32'(1));
        chk("basic_fin_err",   32'(Error), 32'(0));
        chk("basic_fin_busy",  32'(Busy), 32'(1));
        cyc; // cycle 10
        chk("basic_idle_done", 32'(Done), 32'(0));
        chk("basic_idle_busy", 32'(Busy), 32'(0));
        chk("finder_min", 32'(fmin), 32'(1));
        chk("finder_max", 32'(fmax), 32'(9));
        cyc;

        // ---- wrap run: base 30, 4 pairs; stray ConsumerVaild in READ ----
        exp_a = '{5'd30, 5'd31, 5'd0, 5'd1};
        exp_e = '{16'h011E, 16'h011F, 16'd5, 16'd9};
        exp_o = '{16'h021E, 16'h021F, 16'd8, 16'd1};
        BaseAddr = 5'd30; NumPairs = 6'd4; Go = 1'b1;
        cyc; Go = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c <= 4) begin
                chk("wrap_addre", 32'(AddrEven), 32'(exp_a[c-1]));
                chk("wrap_addro", 32'(AddrOdd), 32'(exp_a[c-1]));
            end
            if (c >= 3) begin
                chk("wrap_rde", 32'(ReadDataEven), 32'(exp_e[c-3]));
                chk("wrap_rdo", 32'(ReadDataOdd), 32'(exp_o[c-3]));
            end
            ConsumerVaild = (c == 4);
            cyc;
        end
        ConsumerVaild = 1'b0;
        // cycle 7: the early ConsumerVaild must not have ended the run
        chk("wrap_wait_busy",  32'(Busy), 32'(1));
        chk("wrap_wait_start", 32'(Start), 32'(1));
        chk("wrap_wait_done",  32'(Done), 32'(0));
        ConsumerVaild = 1'b1;
        cyc; ConsumerVaild = 1'b0; // cycle 8
        chk("wrap_fin_done",  32'(Done), 32'(1));
        chk("wrap_fin_start", 32'(Start), 32'(0));
        cyc;
        chk("wrap_idle_busy", 32'(Busy), 32'(0));
        cyc;

        // ---- zero pairs ----
        BaseAddr = 5'd0; NumPairs = 6'd0; Go = 1'b1;
        cyc; Go = 1'b0;
        chk("zero_c1_done",  32'(Done), 32'(1));
        chk("zero_c1_busy",  32'(Busy), 32'(1));
        chk("zero_c1_start", 32'(Start), 32'(0));
        chk("zero_c1_rden",  32'(RdEn), 32'(0));
        cyc;
        chk("zero_c2_done",  32'(Done), 32'(0));
        chk("zero_c2_busy",  32'(Busy), 32'(0));
        chk("zero_c2_start", 32'(Start), 32'(0));
        chk("zero_c2_pv",    32'(PairValid), 32'(0));
        cyc;

        // ---- timeout: 1 pair, ConsumerVaild never arrives ----
        BaseAddr = 5'd0; NumPairs = 6'd1; Go = 1'b1;
        cyc; Go = 1'b0; // cycle 1
        chk("tmo_c1_rden", 32'(RdEn), 32'(1));
        cyc; cyc; // cycle 3
        chk("tmo_c3_pv",    32'(PairValid), 32'(1));
        chk("tmo_c3_start", 32'(Start), 32'(1));
        chk("tmo_c3_rde",   32'(ReadDataEven), 32'(5));
        cyc; // cycle 4: WAIT entry
        start_cnt = 0; done_seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (Start) start_cnt++;
            done_seen = done_seen | Done;
            cyc;
        end
        // cycle 68
        chk("tmo_start_cycles", 32'(start_cnt), 32'(64));
        chk("tmo_no_early_done", 32'(done_seen), 32'(0));
        chk("tmo_done",  32'(Done), 32'(1));
        chk("tmo_err",   32'(Error), 32'(1));
        chk("tmo_start", 32'(Start), 32'(0));
        cyc;
        chk("tmo_idle_busy", 32'(Busy), 32'(0));
        chk("tmo_idle_err",  32'(Error), 32'(1));
        chk("tmo_idle_done", 32'(Done), 32'(0));
        NumPairs = 6'd0; Go = 1'b1;
        cyc; Go = 1'b0;
        chk("tmo_err_clear", 32'(Error), 32'(0));
        chk("tmo_next_done", 32'(Done), 32'(1));
        cyc; cyc;

        // ---- reset mid-run: 8 pairs, reset in cycle 4 ----
        BaseAddr = 5'd0; NumPairs = 6'd8; Go = 1'b1;
        cyc; Go = 1'b0;
        cyc; cyc; cyc; // cycle 4
        chk("rst_c4_busy", 32'(Busy), 32'(1));
        chk("rst_c4_pv",   32'(PairValid), 32'(1));
        chk("rst_c4_rden", 32'(RdEn), 32'(1));
        reset = 1'b1;
        cyc; reset = 1'b0; // cycle 5
        chk_all_zero("rst_mid");
        BaseAddr = 5'd2; NumPairs = 6'd2; Go = 1'b1;
        cyc; Go = 1'b0; // cycle 1
        chk("rst_rerun_addr1", 32'(AddrEven), 32'(2));
        chk("rst_rerun_rden1", 32'(RdEn), 32'(1));
        cyc;
        chk("rst_rerun_addr2", 32'(AddrOdd), 32'(3));
        cyc; // cycle 3
        chk("rst_rerun_pv3",  32'(PairValid), 32'(1));
        chk("rst_rerun_rde3", 32'(ReadDataEven), 32'(2));
        chk("rst_rerun_rdo3", 32'(ReadDataOdd), 32'(6));
        cyc; // cycle 4
        chk("rst_rerun_rde4", 32'(ReadDataEven), 32'(7));
        chk("rst_rerun_rdo4", 32'(ReadDataOdd), 32'(3));
        cyc; // cycle 5: WAIT
        chk("rst_rerun_wait_pv", 32'(PairValid), 32'(0));
        chk("rst_rerun_wait_st", 32'(Start), 32'(1));
        ConsumerVaild = 1'b1;
        cyc; ConsumerVaild = 1'b0; // cycle 6
        chk("rst_rerun_done", 32'(Done), 32'(1));
        chk("rst_rerun_err",  32'(Error), 32'(0));
        cyc; cyc;

        // ---- Go while busy is ignored ----
        BaseAddr = 5'd0; NumPairs = 6'd4; Go = 1'b1;
        cyc; Go = 1'b0; // cycle 1
        chk("busygo_addr1", 32'(AddrEven), 32'(0));
        cyc; // cycle 2
        chk("busygo_addr2", 32'(AddrEven), 32'(1));
        BaseAddr = 5'd10; NumPairs = 6'd7; Go = 1'b1;
        cyc; Go = 1'b0; // cycle 3
        chk("busygo_addr3", 32'(AddrEven), 32'(2));
        chk("busygo_rde3",  32'(ReadDataEven), 32'(5));
        cyc; // cycle 4
        chk("busygo_addr4", 32'(AddrOdd), 32'(3));
        chk("busygo_rden4", 32'(RdEn), 32'(1));
        cyc; // cycle 5
        chk("busygo_rden5", 32'(RdEn), 32'(0));
        cyc; // cycle 6
        chk("busygo_rde6", 32'(ReadDataEven), 32'(7));
        chk("busygo_rdo6", 32'(ReadDataOdd), 32'(3));
        cyc; // cycle 7
        chk("busygo_wait_pv",   32'(PairValid), 32'(0));
        chk("busygo_wait_busy", 32'(Busy), 32'(1));
        ConsumerVaild = 1'b1;
        cyc; ConsumerVaild = 1'b0; // cycle 8
        chk("busygo_done",  32'(Done), 32'(1));
        chk("busygo_start", 32'(Start), 32'(0));
        cyc;
        chk("busygo_idle", 32'(Busy), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
